// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT front end: loader FSM states and frame geometry.
package fft_pkg;

  localparam int FFT_N        = 16;
  localparam int SAMPLE_WIDTH = 12;
  localparam int FFT_LATENCY  = 3;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RST_FFT,
    START,
    WAIT
  } loader_state_t;

endpackage

// File: rtl/sample_bank.sv
// One half of the ping-pong frame buffer: N-entry sample store plus a full/free flag.
module sample_bank #(
  parameter int WIDTH = 12,
  parameter int N     = 16,
  localparam int IW   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [IW-1:0]    wr_idx_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             set_full_i,
  input  logic             clr_full_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o [N]
);

  logic [WIDTH-1:0] mem_q [N];
  logic             full_q;

  // Sample storage is not reset; only the full flag decides whether contents matter.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst)             full_q <= 1'b0;
    else if (set_full_i) full_q <= 1'b1;
    else if (clr_full_i) full_q <= 1'b0;
  end

  assign full_o = full_q;
  assign data_o = mem_q;

endmodule

// File: rtl/fft_frame_loader.sv
// Assembles streamed samples into ping-pong frames and sequences the FFT rst/start/done handshake.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int WIDTH   = SAMPLE_WIDTH,
  parameter int N       = FFT_N,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic [WIDTH-1:0] time_samples [0:N-1],
  output logic             fft_rst,
  output logic             fft_start,
  input  logic             fft_done,
  output logic             spectrum_valid,
  output logic             overflow,
  output logic             timeout_err
);

  localparam int IW = $clog2(N);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  loader_state_t    state_q, state_d;
  logic [IW-1:0]    wr_idx_q, wr_idx_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic             older_q, older_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic             sv_q, sv_d;
  logic             ovf_q, ovf_d;
  logic             tmo_q, tmo_d;
  logic [WIDTH-1:0] ts_q [0:N-1];

  logic [1:0]       full;
  logic [1:0]       bank_we, bank_set, bank_clr;
  logic [WIDTH-1:0] data0 [N];
  logic [WIDTH-1:0] data1 [N];
  logic             wr_en, complete, release_bank;
  logic             fft_rst_s, fft_start_s, load_ts;

  sample_bank #(.WIDTH(WIDTH), .N(N)) u_bank0 (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (bank_we[0]),
    .wr_idx_i   (wr_idx_q),
    .wr_data_i  (sample_in),
    .set_full_i (bank_set[0]),
    .clr_full_i (bank_clr[0]),
    .full_o     (full[0]),
    .data_o     (data0)
  );

  sample_bank #(.WIDTH(WIDTH), .N(N)) u_bank1 (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (bank_we[1]),
    .wr_idx_i   (wr_idx_q),
    .wr_data_i  (sample_in),
    .set_full_i (bank_set[1]),
    .clr_full_i (bank_clr[1]),
    .full_o     (full[1]),
    .data_o     (data1)
  );

  // Write side: a full bank refuses samples, and wr_idx is always 0 then, so frames realign.
  always_comb begin
    wr_en     = sample_valid && !full[wr_bank_q];
    complete  = wr_en && (wr_idx_q == IW'(N - 1));
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    if (wr_en) wr_idx_d = complete ? '0 : wr_idx_q + IW'(1);
    if (complete) wr_bank_d = ~wr_bank_q;
    ovf_d = ovf_q | (sample_valid & full[wr_bank_q]);
    older_d = older_q;
    if (complete && (!full[~wr_bank_q] || (release_bank && (rd_bank_q == ~wr_bank_q))))
      older_d = wr_bank_q;
    bank_we  = {wr_en    &  wr_bank_q, wr_en    & ~wr_bank_q};
    bank_set = {complete &  wr_bank_q, complete & ~wr_bank_q};
    bank_clr = {release_bank & rd_bank_q, release_bank & ~rd_bank_q};
  end

  always_comb begin
    state_d      = state_q;
    rd_bank_d    = rd_bank_q;
    cnt_d        = cnt_q;
    sv_d         = sv_q;
    tmo_d        = tmo_q;
    release_bank = 1'b0;
    fft_rst_s    = 1'b0;
    fft_start_s  = 1'b0;
    load_ts      = 1'b0;
    unique case (state_q)
      INIT: begin
        fft_rst_s = 1'b1;
        state_d   = IDLE;
      end
      IDLE: begin
        if (full[0] && full[1]) begin
          rd_bank_d = older_q;
          state_d   = RST_FFT;
        end else if (full[0] || full[1]) begin
          rd_bank_d = full[1];
          state_d   = RST_FFT;
        end
      end
      RST_FFT: begin
        fft_rst_s = 1'b1;
        load_ts   = 1'b1;
        state_d   = START;
      end
      START: begin
        fft_start_s = 1'b1;
        cnt_d       = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        // done takes priority over a timeout landing on the same cycle
        if (fft_done) begin
          sv_d         = 1'b1;
          release_bank = 1'b1;
          state_d      = IDLE;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = RST_FFT;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: state_d = INIT;
    endcase
    if (state_d == RST_FFT) sv_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      older_q   <= 1'b0;
      cnt_q     <= '0;
      sv_q      <= 1'b0;
      ovf_q     <= 1'b0;
      tmo_q     <= 1'b0;
      for (int k = 0; k < N; k++) ts_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      older_q   <= older_d;
      cnt_q     <= cnt_d;
      sv_q      <= sv_d;
      ovf_q     <= ovf_d;
      tmo_q     <= tmo_d;
      if (load_ts)
        for (int k = 0; k < N; k++) ts_q[k] <= rd_bank_q ? data1[k] : data0[k];
    end
  end

  assign time_samples   = ts_q;
  assign fft_rst        = rst | fft_rst_s;
  assign fft_start      = fft_start_s & ~rst;
  assign spectrum_valid = sv_q;
  assign overflow       = ovf_q;
  assign timeout_err    = tmo_q;

endmodule
